// File: rtl/game_pkg.sv
// Shared encodings and constants for the paddle/ball game sequencer and pixel generator.
package game_pkg;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_SERVE = 3'd1,
        ST_PLAY  = 3'd2,
        ST_PAUSE = 3'd3,
        ST_OVER  = 3'd4
    } state_e;

    typedef enum logic [1:0] {
        DIR_STOP  = 2'd0,
        DIR_LEFT  = 2'd1,
        DIR_RIGHT = 2'd2
    } dir_e;

    localparam logic [7:0] CMD_LEFT  = 8'd108;
    localparam logic [7:0] CMD_RIGHT = 8'd114;
    localparam logic [7:0] CMD_STOP  = 8'd100;
    localparam logic [7:0] CMD_START = 8'd115;
    localparam logic [7:0] CMD_PAUSE = 8'd112;

    localparam logic [9:0] H_VISIBLE = 10'd640;
    localparam logic [9:0] V_VISIBLE = 10'd480;
    localparam logic [9:0] PADDLE_W  = 10'd64;
    localparam logic [9:0] BALL_SIZE = 10'd8;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/game_ctrl_frame_ticker.sv
// Frame-start edge detector and modulo frame counter; flags the last frame of each update period.
module frame_ticker #(
    parameter int unsigned TICK_FRAMES = 6
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    output logic       period
);

    localparam logic [5:0] LAST_FRAME = 6'(TICK_FRAMES - 1);

    logic       fs_s;
    logic       frame_pulse_s;
    logic       fs_q;
    logic [5:0] frame_cnt_q;
    logic [5:0] frame_cnt_d;

    // Origin may be held for many clocks; only its first cycle counts as a frame.
    assign fs_s          = (pixel_x == 10'd0) && (pixel_y == 10'd0);
    assign frame_pulse_s = fs_s && !fs_q;
    assign period        = frame_pulse_s && (frame_cnt_q == LAST_FRAME);

    // Next frame count: advance on each frame start, wrap at the period length.
    always_comb begin
        frame_cnt_d = frame_cnt_q;
        if (frame_pulse_s) begin
            if (frame_cnt_q == LAST_FRAME) begin
                frame_cnt_d = 6'd0;
            end else begin
                frame_cnt_d = frame_cnt_q + 6'd1;
            end
        end else begin
            frame_cnt_d = frame_cnt_q;
        end
    end

    // Edge-detector and counter registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fs_q        <= 1'b0;
            frame_cnt_q <= 6'd0;
        end else begin
            fs_q        <= fs_s;
            frame_cnt_q <= frame_cnt_d;
        end
    end

endmodule

// File: rtl/game_ctrl.sv
// Game sequencer: UART command decode, IDLE/SERVE/PLAY/PAUSE/OVER control, score and lives,
// and registered tick / ball_reset / paddle-move strobes for the pixel generator.
module game_ctrl
    import game_pkg::*;
#(
    parameter int unsigned TICK_FRAMES   = 6,
    parameter int unsigned SERVE_PERIODS = 30,
    parameter int unsigned LIVES         = 3
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [9:0] pixel_x,
    input  logic [9:0] pixel_y,
    input  logic [7:0] rxdata,
    input  logic       rx_valid,
    input  logic       hit,
    input  logic       miss,
    output logic [2:0] state,
    output logic       tick,
    output logic       ball_reset,
    output logic       move_left,
    output logic       move_right,
    output logic [7:0] score,
    output logic [2:0] lives
);

    localparam logic [7:0] SERVE_INIT = 8'(SERVE_PERIODS);
    localparam logic [2:0] LIVES_INIT = 3'(LIVES);

    state_e     state_q, state_d;
    dir_e       dir_q, dir_d;
    logic [7:0] serve_cnt_q, serve_cnt_d;
    logic [7:0] score_q, score_d;
    logic [2:0] lives_q, lives_d;
    logic       tick_q, tick_d;
    logic       ball_reset_q, ball_reset_d;
    logic       move_left_q, move_left_d;
    logic       move_right_q, move_right_d;

    logic period_s;
    logic cmd_left_s, cmd_right_s, cmd_stop_s, cmd_start_s, cmd_pause_s;
    logic serve_entry_s;

    frame_ticker #(
        .TICK_FRAMES(TICK_FRAMES)
    ) u_frame_ticker (
        .clk     (clk),
        .rst_n   (rst_n),
        .pixel_x (pixel_x),
        .pixel_y (pixel_y),
        .period  (period_s)
    );

    assign cmd_left_s  = rx_valid && (rxdata == CMD_LEFT);
    assign cmd_right_s = rx_valid && (rxdata == CMD_RIGHT);
    assign cmd_stop_s  = rx_valid && (rxdata == CMD_STOP);
    assign cmd_start_s = rx_valid && (rxdata == CMD_START);
    assign cmd_pause_s = rx_valid && (rxdata == CMD_PAUSE);

    // Next-state, game bookkeeping and strobe decode.
    always_comb begin
        state_d     = state_q;
        dir_d       = dir_q;
        serve_cnt_d = serve_cnt_q;
        score_d     = score_q;
        lives_d     = lives_q;

        if (cmd_left_s) begin
            dir_d = DIR_LEFT;
        end else if (cmd_right_s) begin
            dir_d = DIR_RIGHT;
        end else if (cmd_stop_s) begin
            dir_d = DIR_STOP;
        end else begin
            dir_d = dir_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (cmd_start_s) state_d = ST_SERVE;
                else             state_d = ST_IDLE;
            end
            ST_SERVE: begin
                if (period_s) begin
                    if (serve_cnt_q == 8'd1) state_d = ST_PLAY;
                    else                     serve_cnt_d = serve_cnt_q - 8'd1;
                end else begin
                    serve_cnt_d = serve_cnt_q;
                end
            end
            ST_PLAY: begin
                // A miss pre-empts any hit or pause arriving in the same cycle.
                if (miss) begin
                    lives_d = lives_q - 3'd1;
                    state_d = (lives_q == 3'd1) ? ST_OVER : ST_SERVE;
                end else begin
                    if (hit) score_d = sat_inc8(score_q);
                    else     score_d = score_q;
                    if (cmd_pause_s) state_d = ST_PAUSE;
                    else             state_d = ST_PLAY;
                end
            end
            ST_PAUSE: begin
                if (cmd_pause_s) state_d = ST_PLAY;
                else             state_d = ST_PAUSE;
            end
            ST_OVER: begin
                if (cmd_start_s) begin
                    state_d = ST_SERVE;
                    score_d = 8'd0;
                    lives_d = LIVES_INIT;
                end else begin
                    state_d = ST_OVER;
                end
            end
            default: state_d = ST_IDLE;
        endcase

        serve_entry_s = (state_d == ST_SERVE) && (state_q != ST_SERVE);
        if (serve_entry_s) begin
            serve_cnt_d = SERVE_INIT;
            dir_d       = DIR_STOP;
        end else begin
            serve_cnt_d = serve_cnt_d;
        end

        tick_d       = period_s && (state_q == ST_PLAY);
        move_left_d  = tick_d && (dir_q == DIR_LEFT);
        move_right_d = tick_d && (dir_q == DIR_RIGHT);
        ball_reset_d = serve_entry_s;
    end

    // State, bookkeeping and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_IDLE;
            dir_q        <= DIR_STOP;
            serve_cnt_q  <= 8'd0;
            score_q      <= 8'd0;
            lives_q      <= LIVES_INIT;
            tick_q       <= 1'b0;
            ball_reset_q <= 1'b0;
            move_left_q  <= 1'b0;
            move_right_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            dir_q        <= dir_d;
            serve_cnt_q  <= serve_cnt_d;
            score_q      <= score_d;
            lives_q      <= lives_d;
            tick_q       <= tick_d;
            ball_reset_q <= ball_reset_d;
            move_left_q  <= move_left_d;
            move_right_q <= move_right_d;
        end
    end

    assign state      = state_q;
    assign tick       = tick_q;
    assign ball_reset = ball_reset_q;
    assign move_left  = move_left_q;
    assign move_right = move_right_q;
    assign score      = score_q;
    assign lives      = lives_q;

endmodule
